op_serializer: RTL and testbench
================================

# op_serializer

Bit-serial transmitter sitting directly downstream of the op encoder in the NeXT monitor-interface path. It accepts one 40-bit op packet when the encoder asserts valid, then shifts it out on the to-monitor line at a fixed bit rate: start bit, then MSB-first payload, then an idle guard gap. It drives `can_send_after` back to the encoder so that a new packet is offered only when the line is free.

## Interface
- `BIT_CLOCKS`, default 8: clock cycles per serial bit; legal range 2..255.
- `GAP_BITS`, default 2: bit periods of forced low line after the last payload bit; legal range 1..15.

Ports:
- `clk` in 1: single system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `data` in 40: packet from the encoder; bits [39:32] are the opcode byte.
- `data_valid` in 1: the packet on `data` is offered this cycle.
- `can_send_after` out 1: high when the serializer is idle and accepts a packet.
- `data_taken` out 1: one-cycle pulse, registered, in the cycle after acceptance.
- `serial_out` out 1: serial line to the monitor; idles low.
- `frame_active` out 1: high from the start bit through the end of the guard gap.

## Operation
- States: IDLE, START, DATA, GAP.
- IDLE: `can_send_after`=1, `serial_out`=0. On the edge where `data_valid`=1:
  - latch `data` into a 40-bit shift register;
  - load the bit counter with the payload length;
  - clear the period counter;
  - set `serial_out`=1, `data_taken`=1, `can_send_after`=0, `frame_active`=1;
  - go to START.
- START: hold `serial_out`=1 for BIT_CLOCKS cycles. Then drive shift reg bit 39 onto `serial_out` and go to DATA.
- DATA: each bit is held BIT_CLOCKS cycles. At the end of a period, shift left by one and present the next MSB. Decrement the bit counter.
  - After the last payload bit's period, set `serial_out`=0 and go to GAP.
- GAP: `serial_out`=0 for GAP_BITS×BIT_CLOCKS cycles. Then go to IDLE with `can_send_after`=1 and `frame_active`=0.
- Payload length: 40 bits, except in the short-frame case described under Configuration.
- `data_valid` outside IDLE is ignored. No `data_taken` is produced and nothing is latched; the encoder must hold or re-present the packet.
- `data` is sampled only on the acceptance edge. Later changes have no effect on the frame in flight.
- `data_taken` is high for exactly one cycle per accepted packet. It is never asserted twice for one frame.
- Period counter width: 8 bits. Gap counter: 4 bits for the bit count plus the period counter. Bit counter: 6 bits.
- Reset (asynchronous, any state, including mid-frame):
  - `serial_out`=0, `can_send_after`=1, `data_taken`=0, `frame_active`=0;
  - state IDLE; all counters and the shift register cleared.
  - The partial frame is abandoned; there is no resume.

## Timing
- Acceptance edge to first payload bit on the line: BIT_CLOCKS cycles (the start bit).
- Full frame (start bit plus 40 payload bits): 41×BIT_CLOCKS cycles high/data.
- Acceptance edge to `can_send_after` high again: (41+GAP_BITS)×BIT_CLOCKS cycles.
- Back-to-back packets: the earliest next acceptance is on the edge after `can_send_after` rises. If `data_valid` is held high continuously, the line shows exactly one IDLE cycle between frames.
- `data_taken` rises in the same cycle as the start bit appears.
- `data_valid` arriving on the edge that returns to IDLE is not accepted on that edge; it is accepted on the next edge.

## Configuration
- `OPSER_SHORT_FRAME_EN`:
  - Defined: if the latched opcode byte equals 8'h07 (audio sample request), the payload length is 8 bits instead of 40. The frame becomes start bit, 8 bits, then the gap. The low 32 bits are not sent.
  - Undefined: every frame carries the full 40 bits, regardless of opcode.

## Test plan
- Reset, then idle, with BIT_CLOCKS=4 and GAP_BITS=2 → `can_send_after`=1, `serial_out`=0, `data_taken`=0 for 20 cycles with `data_valid`=0.
- Offer data=40'hc671000000 for one cycle → next cycle `data_taken`=1 for one cycle. `serial_out` shows high for 4 cycles, then 1100_0110_0111_0001 followed by 24 zeros, each bit held 4 cycles. `can_send_after` returns high 172 cycles after acceptance.
- Offer data=40'h0700000000 with `OPSER_SHORT_FRAME_EN` defined → start bit plus 8'h07 MSB-first, then 8 cycles low. `can_send_after` high after 44 cycles. Without the macro the same stimulus gives 172 cycles.
- Hold `data_valid`=1 with a changing `data` through a frame → one `data_taken` per frame. Each frame carries the value present on its acceptance edge. Exactly one IDLE cycle separates consecutive frames.
- Assert `reset` at payload bit 20 of a 40-bit frame → `serial_out`=0 and `can_send_after`=1 immediately (asynchronously). A packet offered after reset release is sent complete from its start bit.
- Use BIT_CLOCKS=2, GAP_BITS=1 with data=40'hffffffffff → line high for 82 consecutive cycles, then low for 2 cycles, then idle.

Source files
------------

// File: rtl/op_serializer.sv
// Bit-serial transmitter for op packets: start bit, MSB-first payload, low guard gap.
// Optional OPSER_SHORT_FRAME_EN: opcode 8'h07 sends only the 8-bit opcode byte.
module op_serializer #(
  parameter int unsigned BIT_CLOCKS = 8,
  parameter int unsigned GAP_BITS   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [39:0] data,
  input  logic        data_valid,
  output logic        can_send_after,
  output logic        data_taken,
  output logic        serial_out,
  output logic        frame_active
);

  localparam int unsigned PKT_W = 40;
  localparam int unsigned PER_W = 8;
  localparam int unsigned GAP_W = 4;
  localparam int unsigned BIT_W = 6;

  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(BIT_CLOCKS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_BITS - 1);
  localparam logic [BIT_W-1:0] LEN_FULL  = BIT_W'(PKT_W);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [PKT_W-1:0]   shreg_q, shreg_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [BIT_W-1:0]   bits_q, bits_d;
  logic               serial_d, taken_d, can_d, active_d;
  logic [BIT_W-1:0]   load_len_c;
  logic               period_end_c;

`ifdef OPSER_SHORT_FRAME_EN
  localparam logic [7:0]       OP_AUDIO  = 8'h07;
  localparam logic [BIT_W-1:0] LEN_SHORT = BIT_W'(8);
  assign load_len_c = (data[39:32] == OP_AUDIO) ? LEN_SHORT : LEN_FULL;
`else
  assign load_len_c = LEN_FULL;
`endif

  assign period_end_c = (per_q == PER_LAST);

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      shreg_q        <= '0;
      per_q          <= '0;
      gap_q          <= '0;
      bits_q         <= '0;
      serial_out     <= 1'b0;
      data_taken     <= 1'b0;
      can_send_after <= 1'b1;
      frame_active   <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      per_q          <= per_d;
      gap_q          <= gap_d;
      bits_q         <= bits_d;
      serial_out     <= serial_d;
      data_taken     <= taken_d;
      can_send_after <= can_d;
      frame_active   <= active_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    per_d    = per_q;
    gap_d    = gap_q;
    bits_d   = bits_q;
    serial_d = serial_out;
    taken_d  = 1'b0;
    can_d    = can_send_after;
    active_d = frame_active;

    case (state_q)
      S_IDLE: begin
        can_d    = 1'b1;
        serial_d = 1'b0;
        active_d = 1'b0;
        if (data_valid) begin
          shreg_d  = data;
          bits_d   = load_len_c;
          per_d    = '0;
          serial_d = 1'b1;
          taken_d  = 1'b1;
          can_d    = 1'b0;
          active_d = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (period_end_c) begin
          per_d    = '0;
          serial_d = shreg_q[PKT_W-1];
          state_d  = S_DATA;
        end else begin
          per_d = per_q + PER_W'(1);
        end
      end
      S_DATA: begin
        if (period_end_c) begin
          per_d = '0;
          if (bits_q == BIT_LAST) begin
            serial_d = 1'b0;
            gap_d    = '0;
            state_d  = S_GAP;
          end else begin
            // Next bit comes from position 38 because the shift lands this edge
            shreg_d  = shreg_q << 1;
            serial_d = shreg_q[PKT_W-2];
            bits_d   = bits_q - BIT_W'(1);
          end
        end else begin
          per_d = per_q + PER_W'(1);
        end
      end
      S_GAP: begin
        serial_d = 1'b0;
        if (period_end_c) begin
          per_d = '0;
          if (gap_q == GAP_LAST) begin
            can_d    = 1'b1;
            active_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end else begin
          per_d = per_q + PER_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_op_serializer.sv
// Scoreboard bench for op_serializer: a cycle-timing model predicts every line cycle
// of dut_a (BIT_CLOCKS=4, GAP_BITS=2); dut_b (2,1) covers the all-ones boundary frame.
module tb_op_serializer;

  localparam int unsigned BC = 4;
  localparam int unsigned GB = 2;
`ifdef OPSER_SHORT_FRAME_EN
  localparam bit SHORT_EN = 1'b1;
`else
  localparam bit SHORT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [39:0] data = '0;
  logic        data_valid = 1'b0;
  logic        can_send_after, data_taken, serial_out, frame_active;
  logic [39:0] data_b = '0;
  logic        valid_b = 1'b0;
  logic        can_b, taken_b, serial_b, active_b;

  op_serializer #(.BIT_CLOCKS(BC), .GAP_BITS(GB)) dut_a (
    .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
    .can_send_after(can_send_after), .data_taken(data_taken),
    .serial_out(serial_out), .frame_active(frame_active)
  );

  op_serializer #(.BIT_CLOCKS(2), .GAP_BITS(1)) dut_b (
    .clk(clk), .reset(reset), .data(data_b), .data_valid(valid_b),
    .can_send_after(can_b), .data_taken(taken_b),
    .serial_out(serial_b), .frame_active(active_b)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned exp_len(input logic [39:0] d);
    if (SHORT_EN && d[39:32] == 8'h07) return 8;
    return 40;
  endfunction

  // Reference timing model: cycles left in the current frame
  logic [39:0]  q_data[$];
  int unsigned  q_len[$];
  int unsigned  busy = 0;
  int unsigned  frame_total = 0;
  int unsigned  accept_cnt = 0;
  logic         exp_taken = 1'b0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      busy      = 0;
      exp_taken = 1'b0;
    end else if (busy == 0 && data_valid) begin
      q_data.push_back(data);
      q_len.push_back(exp_len(data));
      busy        = (1 + exp_len(data) + GB) * BC;
      frame_total = busy;
      exp_taken   = 1'b1;
      accept_cnt++;
    end else begin
      exp_taken = 1'b0;
      if (busy != 0) busy--;
    end
  end

  // Per-cycle comparison of dut_a against the model, on the falling edge
  logic [39:0] cur_data = '0;
  int unsigned cur_len = 40;
  always @(negedge clk) begin
    int unsigned k;
    logic exp_ser;
    if (chk_en) begin
      k = frame_total - busy;
      if (busy != 0 && k == 0) begin
        check("sb_depth", 64'(q_data.size()), 64'd1);
        if (q_data.size() != 0) begin
          cur_data = q_data.pop_front();
          cur_len  = q_len.pop_front();
        end
      end
      if (busy == 0)                 exp_ser = 1'b0;
      else if (k < BC)               exp_ser = 1'b1;
      else if (k < (1 + cur_len) * BC) exp_ser = cur_data[39 - (k / BC - 1)];
      else                           exp_ser = 1'b0;
      check("can_send_after", can_send_after, busy == 0);
      check("frame_active", frame_active, busy != 0);
      check("data_taken", data_taken, exp_taken);
      check("serial_out", serial_out, exp_ser);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one packet while idle and measure cycles from acceptance to can_send_after
  task automatic send(input logic [39:0] d, output int unsigned lat);
    data       = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (can_send_after) break;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat;
    int unsigned n_taken;
    int unsigned target;
    int unsigned hi, lo;

    repeat (3) tick();
    reset  = 1'b0;
    chk_en = 1'b1;

    // Idle after reset
    repeat (20) tick();
    check("idle_can_send", can_send_after, 1'b1);
    check("idle_serial", serial_out, 1'b0);
    check("idle_taken", data_taken, 1'b0);

    send(40'hc671000000, lat);
    check("lat_full", lat, 172);
    tick();

    send(40'h0700000000, lat);
    check("lat_opcode07", lat, SHORT_EN ? 44 : 172);
    tick();

    // Valid held high with data changing every cycle
    target     = accept_cnt + 3;
    n_taken    = 0;
    data_valid = 1'b1;
    for (int i = 0; i < 1000 && accept_cnt < target; i++) begin
      data = {8'($urandom), 32'($urandom)};
      tick();
      if (data_taken) n_taken++;
    end
    data_valid = 1'b0;
    check("b2b_taken", n_taken, 3);
    for (int i = 0; i < 400 && !can_send_after; i++) tick();
    check("b2b_idle", can_send_after, 1'b1);
    tick();

    // Asynchronous reset during payload bit 20
    data       = 40'hffffffffff;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (21 * BC) tick();
    check("pre_reset_serial", serial_out, 1'b1);
    reset     = 1'b1;
    busy      = 0;
    exp_taken = 1'b0;
    q_data.delete();
    q_len.delete();
    #1;
    check("rst_serial", serial_out, 1'b0);
    check("rst_can_send", can_send_after, 1'b1);
    check("rst_active", frame_active, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    send(40'h123456789a, lat);
    check("lat_after_reset", lat, 172);
    tick();

    // dut_b: all-ones frame at BIT_CLOCKS=2, GAP_BITS=1
    data_b  = '1;
    valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    hi = 0;
    lo = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!serial_b) break;
      hi++;
    end
    for (int i = 0; i < 20; i++) begin
      if (!active_b) break;
      check("b_gap_low", serial_b, 1'b0);
      lo++;
      @(negedge clk);
    end
    check("b_high_cycles", hi, 82);
    check("b_gap_cycles", lo, 2);
    check("b_can_send", can_b, 1'b1);
    tick();

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
